input_conditioner: RTL

Front-end conditioning stage for the board's raw switches and buttons, directly upstream of the timing-test datapath that consumes 4-bit `switches` and `buttons`. Each raw input goes through a multi-flop synchronizer and a per-bit counter debouncer. The block outputs clean, registered levels plus one-cycle button-press pulses. All outputs are glitch-free and synchronous to `clk`.

---
 rtl/input_conditioner.sv | 103 ++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Synchronizes and debounces raw switch/button levels, producing clean levels plus edge pulses.
// Optional macro BTN_RELEASE_EN adds a btn_release pulse output for debounced button releases.
module input_conditioner #(
    parameter int N_SW            = 4,
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_SW-1:0]  switches,
    output logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] btn_press,
`ifdef BTN_RELEASE_EN
    output logic [N_BTN-1:0] btn_release,
`endif
    output logic             sw_changed
);

    localparam int N  = N_SW + N_BTN;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  raw_in;
    logic [N-1:0]  sync_p [SYNC_STAGES];
    logic [N-1:0]  sync_s;
    logic [N-1:0]  stable_q;
    logic [CW-1:0] cnt [N];
    logic [N-1:0]  accept;

    // Switches occupy the low bits, buttons the high bits of one shared vector.
    assign raw_in = {btn_raw, sw_raw};
    assign sync_s = sync_p[SYNC_STAGES-1];

    // Stage: plain flop chain, nothing between stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    always_comb begin
        accept = '0;
        for (int b = 0; b < N; b++) begin
            accept[b] = (sync_s[b] != stable_q[b]) && (cnt[b] == CNT_LAST);
        end
    end

    // Stage: per-bit debounce counter; any agreement restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int b = 0; b < N; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < N; b++) begin
                if (sync_s[b] == stable_q[b]) begin
                    cnt[b] <= '0;
                end else if (accept[b]) begin
                    cnt[b]      <= '0;
                    stable_q[b] <= sync_s[b];
                end else begin
                    cnt[b] <= cnt[b] + CW'(1);
                end
            end
        end
    end

    assign switches = stable_q[N_SW-1:0];
    assign buttons  = stable_q[N-1:N_SW];

    // Stage: pulses are registered on the same edge as the level update so they coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_press  <= '0;
            sw_changed <= 1'b0;
        end else begin
            btn_press  <= accept[N-1:N_SW] & sync_s[N-1:N_SW];
            sw_changed <= |accept[N_SW-1:0];
        end
    end

`ifdef BTN_RELEASE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_release <= '0;
        end else begin
            btn_release <= accept[N-1:N_SW] & ~sync_s[N-1:N_SW];
        end
    end
`endif

endmodule
